// File: rtl/washu_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : washu_disp_pkg
// Description : Shared constants for the washu 7-segment display path:
//               blank patterns for anodes/segments, digit count, and the
//               active-low hex-to-7-segment lookup table (bit order gfedcba).
// Revision    : 1.0 - initial release
// ============================================================================
package washu_disp_pkg;

    // Number of multiplexed digits on the display.
    localparam int NDIG = 4;

    // All-off patterns; the display is common-anode, so everything is active-low.
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Hex digit glyphs, active-low {g,f,e,d,c,b,a}. Entry 15 is leftmost,
    // so HEX7_LUT[n] is the glyph for nibble value n.
    localparam logic [15:0][6:0] HEX7_LUT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage : washu_disp_pkg
`default_nettype wire

// File: rtl/washu_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : washu_hex7seg
// Description : Purely combinational 4-bit hex nibble to active-low
//               7-segment glyph decoder.
// Ports       : i_nib  [3:0] - nibble to decode
//               o_seg  [6:0] - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module washu_hex7seg
    import washu_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX7_LUT[i_nib];

endmodule : washu_hex7seg
`default_nettype wire

// File: rtl/washu_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : washu_seg_scan
// Description : Time-multiplexed scanner driving a common-anode 4-digit
//               7-segment display with a 16-bit hex word. The word and the
//               pause flag are snapshotted once per frame so a frame never
//               mixes old and new digits, and every digit slot starts with a
//               short all-off window to suppress ghosting.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               value[15:0]- word to display; digit k shows value[4k+3:4k]
//               pause_ind  - lights the digit-0 decimal point when set
//               an[3:0]    - anode enables, active-low (an[k] -> digit k)
//               seg[6:0]   - segments {g,f,e,d,c,b,a}, active-low
//               dp         - decimal point, active-low
// Parameters  : REFRESH_DIV  - clock cycles per digit slot (>= 2)
//               BLANK_CYCLES - all-off cycles at the start of each slot
//                              (< REFRESH_DIV)
//               ZERO_BLANK   - 1 suppresses leading-zero digits 3..1
// Revision    : 1.0 - initial release
// ============================================================================
module washu_seg_scan
    import washu_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ZERO_BLANK   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        pause_ind,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int                 c_cnt_w    = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);
    localparam logic [1:0]         c_dig_last = 2'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;     // position inside the current digit slot
    logic [1:0]         r_dig;     // digit currently being scanned
    logic [15:0]        r_snap;    // frame-stable copy of value
    logic               r_snap_p;  // frame-stable copy of pause_ind

    logic               w_tick;       // last cycle of a digit slot
    logic               w_frame_end;  // last cycle of the last slot of a frame
    logic               w_blank;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
    logic [NDIG-1:0]    w_zsup;       // per-digit leading-zero suppression

    assign w_tick      = (r_cnt == c_cnt_last);
    assign w_frame_end = w_tick && (r_dig == c_dig_last);

    // Nibble for the digit under scan; {dig,2'b00} is dig*4.
    assign w_nib = r_snap[{r_dig, 2'b00} +: 4];

    washu_hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // ------------------------------------------------------------------
    // Leading-zero suppression: digit k (k >= 1) goes dark when it and
    // every digit above it are zero. Digit 0 is always lit so that a
    // zero word still shows "0".
    // ------------------------------------------------------------------
    assign w_zsup[0] = 1'b0;

    for (genvar gi = 1; gi < NDIG; gi++) begin : g_zsup
        if (ZERO_BLANK != 0) begin : g_on
            assign w_zsup[gi] = (r_snap[15:4*gi] == '0);
        end else begin : g_off
            assign w_zsup[gi] = 1'b0;
        end
    end

    // Anti-ghosting window at slot start, or a suppressed digit.
    assign w_blank = (r_cnt < c_blank) || w_zsup[r_dig];

    // ------------------------------------------------------------------
    // Prescaler, digit scan, frame snapshot and registered outputs.
    // Outputs are one cycle behind (r_cnt, r_dig, r_snap), which keeps
    // the pins glitch-free regardless of decoder depth.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dig    <= '0;
            r_snap   <= '0;
            r_snap_p <= 1'b0;
            an       <= AN_OFF;
            seg      <= SEG_OFF;
            dp       <= 1'b1;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Captured on the same edge that wraps dig to 0, so the new
            // frame starts with the new snapshot.
            if (w_frame_end) begin
                r_snap   <= value;
                r_snap_p <= pause_ind;
            end

            if (w_blank) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << r_dig);
                seg <= w_seg;
                dp  <= ~(r_snap_p & (r_dig == 2'd0));
            end
        end
    end

endmodule : washu_seg_scan
`default_nettype wire
